// File: rtl/regfile_wb_sched_if.sv
// Write-port scheduler bus: instruction issue, ALU/MEM writeback requesters,
// register file write port and scoreboard status.
interface regfile_wb_sched_if #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int REG_W  = 3
);
   logic              iss_valid;
   logic [REG_W-1:0]  iss_rd;
   logic              iss_ready;
   logic              alu_valid;
   logic [REG_W-1:0]  alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [REG_W-1:0]  mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              write;
   logic [REG_W-1:0]  writenum;
   logic [DATA_W-1:0] data_in;
   logic [NREG-1:0]   busy;
   logic              wb_err;

   modport slave (
      input  iss_valid, iss_rd,
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      output iss_ready, alu_ready, mem_ready,
      output write, writenum, data_in, busy, wb_err
   );

   modport master (
      output iss_valid, iss_rd,
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      input  iss_ready, alu_ready, mem_ready,
      input  write, writenum, data_in, busy, wb_err
   );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and scoreboard for the 8x16 register file.
// Round-robin arbitrates ALU and MEM writebacks onto one registered write
// port, tracks pending writes per register and blocks WAW issue.
module regfile_wb_sched #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int REG_W  = 3
) (
   input logic              clk,
   input logic              rst_n,
   regfile_wb_sched_if.slave bus
);

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

   req_e              rr_last_q, rr_last_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic              write_q, write_d;
   logic [REG_W-1:0]  writenum_q, writenum_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic              wb_err_q, wb_err_d;
   logic              grant_alu, grant_mem;

   // Grant: a lone requester always wins; on a tie the one not served last wins.
   always_comb begin
      grant_alu = bus.alu_valid & (~bus.mem_valid | (rr_last_q == REQ_MEM));
      grant_mem = bus.mem_valid & (~bus.alu_valid | (rr_last_q == REQ_ALU));
   end

   // Next state: capture the granted transfer, update scoreboard and error flag.
   always_comb begin
      busy_d     = busy_q;
      write_d    = grant_alu | grant_mem;
      writenum_d = writenum_q;
      data_in_d  = data_in_q;
      wb_err_d   = wb_err_q;
      rr_last_d  = rr_last_q;

      if (grant_alu) begin
         writenum_d = bus.alu_rd;
         data_in_d  = bus.alu_data;
         rr_last_d  = REQ_ALU;
      end else if (grant_mem) begin
         writenum_d = bus.mem_rd;
         data_in_d  = bus.mem_data;
         rr_last_d  = REQ_MEM;
      end

      if (write_d && !busy_q[writenum_d]) begin
         wb_err_d = 1'b1;
      end

      // Clear first, then set: the same register cannot be both, since issue
      // to a busy register is refused.
      if (write_q) begin
         busy_d[writenum_q] = 1'b0;
      end
      if (bus.iss_valid && !busy_q[bus.iss_rd]) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
   end

   // State registers; reset discards any pending write and all busy bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q  <= REQ_MEM;
         busy_q     <= '0;
         write_q    <= 1'b0;
         writenum_q <= '0;
         data_in_q  <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         rr_last_q  <= rr_last_d;
         busy_q     <= busy_d;
         write_q    <= write_d;
         writenum_q <= writenum_d;
         data_in_q  <= data_in_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign bus.iss_ready = ~busy_q[bus.iss_rd];
   assign bus.alu_ready = grant_alu;
   assign bus.mem_ready = grant_mem;
   assign bus.write     = write_q;
   assign bus.writenum  = writenum_q;
   assign bus.data_in   = data_in_q;
   assign bus.busy      = busy_q;
   assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios followed by random traffic,
// checked by a negedge monitor against a queue-based reference model.
module tb_regfile_wb_sched;
   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int REG_W  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   regfile_wb_sched_if #(.DATA_W(DATA_W), .NREG(NREG), .REG_W(REG_W)) bus ();

   regfile_wb_sched #(.DATA_W(DATA_W), .NREG(NREG), .REG_W(REG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and monitor ----------------
   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t             exp_q[$];
   logic [NREG-1:0] m_busy = '0;
   logic [NREG-1:0] m_old;
   logic            m_last_mem = 1'b1;
   logic            m_err = 1'b0;
   logic            e_alu, e_mem;
   wr_t             m_w;
   int              a_wait = 0;
   int              b_wait = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = '0;
         m_last_mem = 1'b1;
         m_err = 1'b0;
         exp_q.delete();
         a_wait = 0;
         b_wait = 0;
      end else begin
         m_old = m_busy;
         chk("busy", bus.busy, m_busy);
         chk("wb_err", bus.wb_err, m_err);
         if (bus.iss_valid) chk("iss_ready", bus.iss_ready, !m_busy[bus.iss_rd]);

         e_alu = bus.alu_valid && (!bus.mem_valid || m_last_mem);
         e_mem = bus.mem_valid && (!bus.alu_valid || !m_last_mem);
         chk("alu_ready", bus.alu_ready, e_alu);
         chk("mem_ready", bus.mem_ready, e_mem);

         chk("write", bus.write, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            m_w = exp_q.pop_front();
            if (bus.write) begin
               chk("writenum", bus.writenum, m_w.rd);
               chk("data_in", bus.data_in, m_w.data);
            end
            m_busy[m_w.rd] = 1'b0;
         end
         if (bus.iss_valid && !m_old[bus.iss_rd]) m_busy[bus.iss_rd] = 1'b1;

         if (e_alu) begin
            exp_q.push_back({bus.alu_rd, bus.alu_data});
            m_last_mem = 1'b0;
            if (!m_old[bus.alu_rd]) m_err = 1'b1;
         end else if (e_mem) begin
            exp_q.push_back({bus.mem_rd, bus.mem_data});
            m_last_mem = 1'b1;
            if (!m_old[bus.mem_rd]) m_err = 1'b1;
         end

         if (bus.alu_valid && !e_alu) a_wait++; else a_wait = 0;
         if (bus.mem_valid && !e_mem) b_wait++; else b_wait = 0;
         if (bus.alu_valid) chk("alu_grant_wait", a_wait > 1, 0);
         if (bus.mem_valid) chk("mem_grant_wait", b_wait > 1, 0);
      end
   end

   // ---------------- driver ----------------
   logic             acc_a, acc_m, acc_i;
   logic [REG_W-1:0] acc_rd;
   logic [REG_W-1:0] issued[$];

   task automatic step();
      @(negedge clk);
      acc_a  = bus.alu_valid & bus.alu_ready;
      acc_m  = bus.mem_valid & bus.mem_ready;
      acc_i  = bus.iss_valid & bus.iss_ready;
      acc_rd = bus.iss_rd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iss_valid = 1'b0; bus.iss_rd = '0;
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
   endtask

   function automatic logic [REG_W-1:0] pick_rd();
      if (issued.size() > 0 && $urandom_range(7, 0) != 0) return issued.pop_front();
      return REG_W'($urandom_range(NREG - 1, 0));
   endfunction

   initial begin
      idle_inputs();
      #1 rst_n = 1'b0;
      #1;
      // reset state
      for (int r = 0; r < NREG; r++) begin
         bus.iss_rd = REG_W'(r);
         #1 chk("rst_iss_ready", bus.iss_ready, 1);
      end
      chk("rst_busy", bus.busy, 8'h00);
      chk("rst_write", bus.write, 0);
      chk("rst_writenum", bus.writenum, 0);
      chk("rst_data_in", bus.data_in, 0);
      chk("rst_wb_err", bus.wb_err, 0);
      bus.iss_rd = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // issue rd=3, ALU writeback two cycles later
      bus.iss_valid = 1'b1; bus.iss_rd = 3'd3;
      step();
      bus.iss_valid = 1'b0;
      chk("t2_busy_set", bus.busy, 8'h08);
      step();
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 16'hBEEF;
      #1 chk("t2_alu_ready", bus.alu_ready, 1);
      step();
      bus.alu_valid = 1'b0;
      chk("t2_write", bus.write, 1);
      chk("t2_writenum", bus.writenum, 3);
      chk("t2_data_in", bus.data_in, 16'hBEEF);
      step();
      chk("t2_busy_clr", bus.busy, 8'h00);
      chk("t2_write_off", bus.write, 0);

      // MEM writeback to a non-busy register
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd6; bus.mem_data = 16'h1234;
      #1 chk("t5_mem_ready", bus.mem_ready, 1);
      step();
      bus.mem_valid = 1'b0;
      chk("t5_write", bus.write, 1);
      chk("t5_writenum", bus.writenum, 6);
      chk("t5_wb_err", bus.wb_err, 1);
      repeat (3) step();
      chk("t5_wb_err_sticky", bus.wb_err, 1);

      // both requesters continuously valid: strict alternation starting with ALU
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'($urandom);
      bus.mem_valid = 1'b1; bus.mem_rd = 3'd2; bus.mem_data = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t3_alu_grant", bus.alu_ready, (k % 2) == 0);
         chk("t3_mem_grant", bus.mem_ready, (k % 2) == 1);
         if (k > 0) chk("t3_write_order", bus.writenum, ((k - 1) % 2 == 0) ? 1 : 2);
         step();
         if (acc_a) bus.alu_data = 16'($urandom);
         if (acc_m) bus.mem_data = 16'($urandom);
      end
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
      chk("t3_last_write", bus.writenum, 2);
      step();

      // WAW stall on busy register 5
      bus.iss_valid = 1'b1; bus.iss_rd = 3'd5;
      step();
      #1 chk("t4_stall0", bus.iss_ready, 0);
      step();
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd5; bus.alu_data = 16'h5555;
      #1 chk("t4_alu_ready", bus.alu_ready, 1);
      chk("t4_stall1", bus.iss_ready, 0);
      step();
      bus.alu_valid = 1'b0;
      #1 chk("t4_write5", bus.write, 1);
      chk("t4_stall2", bus.iss_ready, 0);
      step();
      #1 chk("t4_release", bus.iss_ready, 1);
      step();
      bus.iss_valid = 1'b0;

      // async reset in the cycle with write=1
      bus.alu_valid = 1'b1; bus.alu_rd = 3'd5; bus.alu_data = 16'h6666;
      #1 chk("t6_alu_ready", bus.alu_ready, 1);
      step();
      idle_inputs();
      chk("t6_pre_write", bus.write, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_write", bus.write, 0);
      chk("t6_busy", bus.busy, 8'h00);
      chk("t6_wb_err", bus.wb_err, 0);
      @(negedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // random traffic
      issued.delete();
      for (int c = 0; c < 1500; c++) begin
         step();
         if (acc_i) issued.push_back(acc_rd);
         bus.iss_valid = 1'($urandom_range(1, 0));
         bus.iss_rd    = REG_W'($urandom_range(NREG - 1, 0));
         if (!bus.alu_valid || acc_a) begin
            if ($urandom_range(2, 0) == 0) begin
               bus.alu_valid = 1'b1;
               bus.alu_rd    = pick_rd();
               bus.alu_data  = 16'($urandom);
            end else begin
               bus.alu_valid = 1'b0;
            end
         end
         if (!bus.mem_valid || acc_m) begin
            if ($urandom_range(2, 0) == 0) begin
               bus.mem_valid = 1'b1;
               bus.mem_rd    = pick_rd();
               bus.mem_data  = 16'($urandom);
            end else begin
               bus.mem_valid = 1'b0;
            end
         end
      end
      idle_inputs();
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
